div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
// - Multi-cycle sequencer for the RV32M divide ops (DIV, DIVU, REM, REMU), which the single-cycle ALU does not implement.
// - Runs a radix-2 restoring divider, one quotient bit per clock. It is started from the EX stage and raises Busy to stall the pipeline.
// - Handles the RISC-V divide-by-zero and signed-overflow cases without iterating.
// PARAMETERS
// - XLEN  32  operand/result width; counter width is $clog2(XLEN)
// PORTS
// - clk        in   1     clock, rising edge
// - rst        in   1     asynchronous, active-high reset
// - Start      in   1     request; accepted only in IDLE
// - Op         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
// - A          in   XLEN  dividend (rs1)
// - B          in   XLEN  divisor (rs2)
// - Flush      in   1     abort any in-flight op (pipeline flush)
// - Busy       out  1     1 in CALC/FIX; EX stage stalls on Busy | Start
// - Done       out  1     one-cycle pulse in DONE; Result valid
// - Result     out  XLEN  quotient or remainder; held until the next accepted Start
// BEHAVIOUR
// - Reset: state=IDLE, Busy=0, Done=0, Result=0, counter=0, internal regs=0.
// - States and transitions:
//   - IDLE -> CALC when Start & ~Flush, normal case.
//   - IDLE -> DONE when Start & ~Flush, special case.
//   - CALC -> FIX after XLEN iterations.
//   - FIX -> DONE.
//   - DONE -> IDLE.
// - Accept edge E0:
//   - Capture Op.
//   - Signed ops: capture |A| and |B|, plus the sign of the quotient (A[31]^B[31]) and of the remainder (A[31]).
//   - Clear remainder register; counter=0.
// - CALC, one edge per bit:
//   - rem = {rem[XLEN-2:0], dvd[XLEN-1]} - dvs.
//   - If no borrow, keep the difference and shift in q=1; otherwise restore and shift in q=0.
//   - 32 iterations on edges E1..E32.
// - FIX (edge E33): negate quotient/remainder per captured signs; register Result; enter DONE.
// - Latency: Done is high in the cycle after E33, 33 cycles after the accept edge. Special cases give Done in the cycle after E0.
// - Special cases, decided at E0 with no iteration:
//   - B==0: DIV/DIVU -> all ones; REM/REMU -> A.
//   - Signed overflow (A==0x80000000, B==0xFFFFFFFF, Op DIV/REM): DIV -> 0x80000000; REM -> 0.
// - Abs arithmetic is XLEN-bit unsigned. |0x80000000| = 0x80000000 is valid unsigned, so no extra bit is needed.
// - Start while not IDLE: ignored, no queueing. Start in the DONE cycle is ignored; it is re-presented next cycle, since the stall holds it.
// - Flush, synchronous: any state -> IDLE at the next edge.
//   - Busy and Done fall; Result keeps its last completed value; no Done for the aborted op.
//   - Flush with Start in the same cycle: Flush wins and Start is dropped.
// - Reset mid-operation: immediate return to reset values; no Done.
// CONFIGURATION
// - DIV_RESULT_CACHE_EN defined:
//   - Each completed normal op stores A, B, the signedness (Op[0]), the final quotient and remainder, and a valid bit.
//   - On Start in IDLE with a cache hit (valid, same A/B/signedness): go straight to DONE. Result = cached quotient or remainder per Op[1]; latency 1.
//   - Reset clears the valid bit; Flush does not, and an aborted op never updates the cache.
// - Macro undefined:
//   - No cache storage is built.
//   - Every normal op takes the full 33-cycle path.
// TESTING
// - DIVU 100/7: Busy high 33 cycles; Done high exactly one cycle, 33 cycles after accept; Result=14.
// - REM -7 (0xFFFFFFF9) by 2 -> Result=0xFFFFFFFF (-1, dividend sign); DIV same operands -> 0xFFFFFFFD (-3).
// - Divide by zero, 1-cycle latency, Busy never high: DIV 5/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
// - Signed overflow, 1-cycle latency: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
// - Flush 10 cycles into DIVU 100/7: Busy=0 next cycle, no Done, Result unchanged. New Start then completes normally. Also check Start+Flush together -> no accept.
// - With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> 2 with Done 1 cycle after accept; without the macro -> 2 after 33 cycles.

Source files
------------

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle sequencer for the RV32M divide ops (DIV, DIVU, REM,
//               REMU). It uses a radix-2 restoring divider that produces one
//               quotient bit per clock. Divide-by-zero and signed overflow are
//               resolved on the accept edge without iterating.
//               Optional macro DIV_RESULT_CACHE_EN adds a one-entry result
//               cache. On a hit, the op completes with single-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int              c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op_rem;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [XLEN-1:0]    r_dvd;
    logic [XLEN-1:0]    r_dvs;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_result;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [XLEN-1:0]    w_special_result;
    logic               w_hit;
    logic [XLEN-1:0]    w_hit_result;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic               w_borrow;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_remd;

    assign w_accept   = (r_state == c_idle) & Start & ~Flush;
    assign w_signed   = ~Op[0];
    assign w_a_neg    = w_signed & A[XLEN-1];
    assign w_b_neg    = w_signed & B[XLEN-1];
    // Magnitudes stay XLEN-bit unsigned; the most negative value maps onto itself, which is still correct.
    assign w_abs_a    = w_a_neg ? (~A + 1'b1) : A;
    assign w_abs_b    = w_b_neg ? (~B + 1'b1) : B;
    assign w_div_zero = (B == '0);
    assign w_ovf      = w_signed & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
    assign w_special  = w_div_zero | w_ovf;

    // Architectural results for the cases that skip iteration.
    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = Op[1] ? A : '1;
        end else if (w_ovf) begin
            w_special_result = Op[1] ? '0 : A;
        end
    end

    // The partial remainder shift keeps its carry-out bit. The remainder is always
    // below the divisor, and a divisor above 2^(XLEN-1) can make the shifted value
    // need XLEN+1 bits.
    assign w_shift  = {r_rem, r_dvd[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_borrow = w_diff[XLEN];
    assign w_quot   = r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
    assign w_remd   = r_r_neg ? (~r_rem + 1'b1) : r_rem;
    assign Result   = r_result;

`ifdef DIV_RESULT_CACHE_EN
    logic            r_a;
    logic            r_c_valid;
    logic            r_c_uns;
    logic            r_a_uns;
    logic [XLEN-1:0] r_a_val;
    logic [XLEN-1:0] r_b_val;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_quot;
    logic [XLEN-1:0] r_c_rem;

    assign w_hit        = r_c_valid & (A == r_c_a) & (B == r_c_b) & (Op[0] == r_c_uns);
    assign w_hit_result = Op[1] ? r_c_rem : r_c_quot;

    // This block holds the operands of the in-flight op. It commits them to the cache
    // only when the op finishes FIX normally. A flushed op is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= 1'b0;
            r_a_uns   <= 1'b0;
            r_a_val   <= '0;
            r_b_val   <= '0;
            r_c_valid <= 1'b0;
            r_c_uns   <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_quot  <= '0;
            r_c_rem   <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= 1'b1;
                r_a_uns <= Op[0];
                r_a_val <= A;
                r_b_val <= B;
            end
            if ((r_state == c_fix) && !Flush && r_a) begin
                r_c_valid <= 1'b1;
                r_c_uns   <= r_a_uns;
                r_c_a     <= r_a_val;
                r_c_b     <= r_b_val;
                r_c_quot  <= w_quot;
                r_c_rem   <= w_remd;
            end
        end
    end
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and status outputs. Flush has priority over every transition.
    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_next_state = (w_special | w_hit) ? c_done : c_calc;
                end
            end
            c_calc: begin
                Busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_next_state = c_fix;
                end
            end
            c_fix: begin
                Busy         = 1'b1;
                w_next_state = c_done;
            end
            c_done: begin
                Done         = 1'b1;
                w_next_state = c_idle;
            end
            default: w_next_state = c_idle;
        endcase
        if (Flush) begin
            w_next_state = c_idle;
        end
    end

    // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (!Flush) begin
            case (r_state)
                c_idle: begin
                    if (Start) begin
                        r_op_rem <= Op[1];
                        r_q_neg  <= w_a_neg ^ w_b_neg;
                        r_r_neg  <= w_a_neg;
                        r_dvd    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        if (w_special) begin
                            r_result <= w_special_result;
                        end else if (w_hit) begin
                            r_result <= w_hit_result;
                        end
                    end
                end
                c_calc: begin
                    r_rem <= w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                    r_dvd <= {r_dvd[XLEN-2:0], ~w_borrow};
                    r_cnt <= r_cnt + 1'b1;
                end
                c_fix: begin
                    r_result <= r_op_rem ? w_remd : w_quot;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed self-checking bench for div_sequencer. Expected results
//               are queued when an op is issued and popped on Done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

`ifdef DIV_RESULT_CACHE_EN
    localparam int c_hit_lat  = 1;
    localparam int c_hit_busy = 0;
`else
    localparam int c_hit_lat  = 34;
    localparam int c_hit_busy = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    logic [31:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for Done. Latency counts clock edges from the accept edge (inclusive) until Done is seen.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_busy, input bit poke);
        int cyc;
        int busy_cnt;
        logic [31:0] e;
        @(negedge clk);
        Start = 1'b1; Op = op; A = a; B = b;
        sb.push_back(exp_res);
        @(negedge clk);
        Start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!Done && cyc < 100) begin
            if (Busy) busy_cnt++;
            if (poke && cyc == 5) begin
                Start = 1'b1; Op = 2'b01; A = 32'h1234_5678; B = 32'd3;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;
        chk({tag, " done"}, {31'd0, Done}, 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " busy"}, 32'(busy_cnt), 32'(exp_busy));
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk({tag, " result"}, Result, e);
        @(negedge clk);
        chk({tag, " done width"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        int seen;
        #1;
        chk("reset busy", {31'd0, Busy}, 32'd0);
        chk("reset done", {31'd0, Done}, 32'd0);
        chk("reset result", Result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 33, 1'b0);
        do_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33, 1'b0);
        do_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, c_hit_lat, c_hit_busy, 1'b0);
        do_op("div 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        do_op("remu x/0", 2'b11, 32'h1234, 32'd0, 32'h1234, 1, 0, 1'b0);
        do_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
        do_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
        do_op("divu big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 33, 1'b0);
        do_op("remu big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, c_hit_lat, c_hit_busy, 1'b0);
        do_op("div -100/7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33, 1'b0);
        do_op("rem 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 34, 33, 1'b0);

        // Abort an op 10 cycles in.
        @(negedge clk);
        Start = 1'b1; Op = 2'b01; A = 32'd200; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        chk("flush busy", {31'd0, Busy}, 32'd0);
        chk("flush done", {31'd0, Done}, 32'd0);
        chk("flush result", Result, 32'd2);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen++;
        end
        chk("flush no done", 32'(seen), 32'd0);

        // Start and Flush together: nothing is accepted.
        Start = 1'b1; Flush = 1'b1; Op = 2'b01; A = 32'd200; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        chk("start+flush busy", {31'd0, Busy}, 32'd0);
        chk("start+flush done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        chk("start+flush idle", {31'd0, Busy | Done}, 32'd0);

        do_op("divu 200/7", 2'b01, 32'd200, 32'd7, 32'd28, 34, 33, 1'b0);
        do_op("div 100/7", 2'b00, 32'd100, 32'd7, 32'd14, 34, 33, 1'b0);
        do_op("rem 100/7", 2'b10, 32'd100, 32'd7, 32'd2, c_hit_lat, c_hit_busy, 1'b0);
        do_op("divu poke", 2'b01, 32'd1000, 32'd10, 32'd100, 34, 33, 1'b1);

        // Asynchronous reset in the middle of an op.
        @(negedge clk);
        Start = 1'b1; Op = 2'b01; A = 32'd999; B = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, Busy}, 32'd0);
        chk("midrst done", {31'd0, Done}, 32'd0);
        chk("midrst result", Result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("rem after rst", 2'b10, 32'd100, 32'd7, 32'd2, 34, 33, 1'b0);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
